// File: rtl/sr_mem_pkg.sv
// ---------------------------------------------------------------------------
// sr_mem_pkg
// Shared definitions for the SR latch array reader:
//   - sr_state_e : reader FSM state encoding
//   - DEF_WORDS / DEF_WIDTH : default array geometry
//   - SETTLE_W   : width of the settle counter (holds 1..15)
//   - sat_inc16  : saturating 16-bit increment used by the statistics counters
// ---------------------------------------------------------------------------
package sr_mem_pkg;

  localparam int DEF_WORDS = 8;
  localparam int DEF_WIDTH = 8;
  localparam int SETTLE_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_RESP   = 3'd4
  } sr_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sr_word_mux.sv
// ---------------------------------------------------------------------------
// sr_word_mux
// Selects one WIDTH-bit word from the packed Q and NQ buses of the latch
// array and flags every bit whose Q and NQ agree (forbidden latch state).
// Ports:
//   sel_i      word index
//   q_bus_i    packed Q outputs, word n at [n*WIDTH +: WIDTH]
//   nq_bus_i   packed NQ outputs, same packing
//   q_word_o   selected Q word
//   nq_word_o  selected NQ word
//   invalid_o  per-bit flag, 1 where Q == NQ
// ---------------------------------------------------------------------------
module sr_word_mux
  import sr_mem_pkg::*;
#(
  parameter int WORDS = DEF_WORDS,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [$clog2(WORDS)-1:0] sel_i,
  input  logic [WORDS*WIDTH-1:0]   q_bus_i,
  input  logic [WORDS*WIDTH-1:0]   nq_bus_i,
  output logic [WIDTH-1:0]         q_word_o,
  output logic [WIDTH-1:0]         nq_word_o,
  output logic [WIDTH-1:0]         invalid_o
);

  logic [WIDTH-1:0] q_words  [WORDS];
  logic [WIDTH-1:0] nq_words [WORDS];

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_unpack
    assign q_words[gi]  = q_bus_i[gi*WIDTH +: WIDTH];
    assign nq_words[gi] = nq_bus_i[gi*WIDTH +: WIDTH];
  end

  assign q_word_o  = q_words[sel_i];
  assign nq_word_o = nq_words[sel_i];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_invalid
    assign invalid_o[gi] = ~(q_word_o[gi] ^ nq_word_o[gi]);
  end

endmodule

// File: rtl/sr_array_reader.sv
// ---------------------------------------------------------------------------
// sr_array_reader
// Reads one word from an array of SR latches. After the address is captured
// the reader waits SETTLE_CYCLES, takes two consecutive samples (A, B) of
// the Q/NQ word and responds once they agree. Disagreeing samples trigger a
// re-settle, up to MAX_RETRY times; a forbidden latch state (Q == NQ on any
// bit) or exhausted retries report ERR.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   REQ            read request (level, held until ACK)
//   ADDR           word select, captured when a request is accepted
//   Q_BUS, NQ_BUS  packed latch outputs, word n at [n*WIDTH +: WIDTH]
//   ACK            response valid (high in RESP)
//   DATA, ERR      result, held until the next completed read
//   BUSY           high in every state except IDLE
//   RD_COUNT, ERR_COUNT  (only with SR_READER_STATS_EN) saturating counts
//                  of completed reads without / with error
// Optional feature macro: SR_READER_STATS_EN
// ---------------------------------------------------------------------------
module sr_array_reader
  import sr_mem_pkg::*;
#(
  parameter int WORDS         = DEF_WORDS,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ,
  input  logic [$clog2(WORDS)-1:0] ADDR,
  input  logic [WORDS*WIDTH-1:0]   Q_BUS,
  input  logic [WORDS*WIDTH-1:0]   NQ_BUS,
  output logic                     ACK,
  output logic [WIDTH-1:0]         DATA,
  output logic                     ERR,
  output logic                     BUSY
`ifdef SR_READER_STATS_EN
  ,
  output logic [15:0]              RD_COUNT,
  output logic [15:0]              ERR_COUNT
`endif
);

  localparam int AW = $clog2(WORDS);
  // Retry counter must hold 0..MAX_RETRY; keep at least one bit.
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]       RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);

  sr_state_e           state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [WIDTH-1:0]    a_word_q, a_word_d;
  logic [WIDTH-1:0]    a_nword_q, a_nword_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                err_q, err_d;
  logic                done_d;

  logic [WIDTH-1:0] word_q, word_nq, word_invalid;

  sr_word_mux #(
    .WORDS (WORDS),
    .WIDTH (WIDTH)
  ) u_mux (
    .sel_i     (addr_q),
    .q_bus_i   (Q_BUS),
    .nq_bus_i  (NQ_BUS),
    .q_word_o  (word_q),
    .nq_word_o (word_nq),
    .invalid_o (word_invalid)
  );

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    retry_d   = retry_q;
    addr_d    = addr_q;
    a_word_d  = a_word_q;
    a_nword_d = a_nword_q;
    data_d    = data_q;
    err_d     = err_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          addr_d   = ADDR;
          settle_d = SETTLE_LD;
          retry_d  = '0;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        settle_d = settle_q - 1'b1;
        if (settle_q == SETTLE_W'(1)) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        a_word_d  = word_q;
        a_nword_d = word_nq;
        state_d   = ST_CHECK;
      end

      // Sample B is the live mux output in this cycle; only its Q word is
      // kept (as DATA), so it is evaluated here rather than re-registered.
      ST_CHECK: begin
        if (|word_invalid) begin
          data_d  = word_q;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_RESP;
        end else if ((a_word_q == word_q) && (a_nword_q == word_nq)) begin
          data_d  = word_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_RESP;
        end else if (retry_q < RETRY_MAX) begin
          retry_d  = retry_q + 1'b1;
          settle_d = SETTLE_LD;
          state_d  = ST_SETTLE;
        end else begin
          data_d  = word_q;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (!REQ) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      retry_q   <= '0;
      addr_q    <= '0;
      a_word_q  <= '0;
      a_nword_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      retry_q   <= retry_d;
      addr_q    <= addr_d;
      a_word_q  <= a_word_d;
      a_nword_q <= a_nword_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign ACK  = (state_q == ST_RESP);
  assign BUSY = (state_q != ST_IDLE);
  assign DATA = data_q;
  assign ERR  = err_q;

`ifdef SR_READER_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (done_d) begin
      if (err_d) begin
        err_cnt_d = sat_inc16(err_cnt_q);
      end else begin
        rd_cnt_d = sat_inc16(rd_cnt_q);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign RD_COUNT  = rd_cnt_q;
  assign ERR_COUNT = err_cnt_q;
`else
  // Completion pulse only feeds the statistics counters.
  logic unused_done;
  assign unused_done = done_d;
`endif

endmodule

// File: tb/tb_sr_array_reader.sv
// ---------------------------------------------------------------------------
// tb_sr_array_reader
// Self-checking bench for sr_array_reader (default parameters). Expected
// results are pushed to a scoreboard when a request is driven and popped
// when ACK appears. Latency is counted in clock edges from the cycle the
// request is first presented, the accepting edge being edge 1.
// Optional feature macro: SR_READER_STATS_EN
// ---------------------------------------------------------------------------
module tb_sr_array_reader;

  localparam int WORDS  = 8;
  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;
  localparam int RETRY  = 3;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               lat;
  } exp_t;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic                   REQ;
  logic [2:0]             ADDR;
  logic [WORDS*WIDTH-1:0] Q_BUS;
  logic [WORDS*WIDTH-1:0] NQ_BUS;
  logic                   ACK;
  logic [WIDTH-1:0]       DATA;
  logic                   ERR;
  logic                   BUSY;
`ifdef SR_READER_STATS_EN
  logic [15:0]            RD_COUNT;
  logic [15:0]            ERR_COUNT;
`endif

  logic [WIDTH-1:0] qw  [WORDS];
  logic [WIDTH-1:0] nqw [WORDS];
  logic             toggle_en = 1'b0;
  logic             tog = 1'b0;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  sr_array_reader #(
    .WORDS         (WORDS),
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE),
    .MAX_RETRY     (RETRY)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .ADDR   (ADDR),
    .Q_BUS  (Q_BUS),
    .NQ_BUS (NQ_BUS),
    .ACK    (ACK),
    .DATA   (DATA),
    .ERR    (ERR),
    .BUSY   (BUSY)
`ifdef SR_READER_STATS_EN
    ,
    .RD_COUNT  (RD_COUNT),
    .ERR_COUNT (ERR_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Word 0 can be switched to a source that flips every cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (toggle_en) tog = ~tog;
      else           tog = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      Q_BUS[i*WIDTH +: WIDTH]  = qw[i];
      NQ_BUS[i*WIDTH +: WIDTH] = nqw[i];
    end
    if (toggle_en) begin
      Q_BUS[0 +: WIDTH]  = {WIDTH{tog}};
      NQ_BUS[0 +: WIDTH] = {WIDTH{~tog}};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [WIDTH-1:0] exp_data,
                         input logic exp_err, input int exp_lat,
                         input int change_at, input logic [WIDTH-1:0] new_q,
                         input bit drop_early);
    exp_t e;
    int   lat;
    bit   got;
    sb.push_back('{data: exp_data, err: exp_err, lat: exp_lat});
    ADDR = a;
    REQ  = 1'b1;
    got  = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (ACK) begin
        lat = c;
        got = 1'b1;
        break;
      end
      if (c == 1) begin
        ADDR = ~a;
        if (drop_early) REQ = 1'b0;
      end
      if (c == change_at) begin
        qw[a]  = new_q;
        nqw[a] = ~new_q;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
      REQ = 1'b0;
      return;
    end
    check("data", DATA, e.data);
    check("err", ERR, e.err);
    check("latency", lat, e.lat);
    check("busy_resp", BUSY, 1'b1);
    $display("read addr=%0d data=%0h err=%0b lat=%0d", a, DATA, ERR, lat);
    if (!drop_early) begin
      tick();
      check("ack_hold", ACK, 1'b1);
      check("data_hold", DATA, e.data);
      REQ = 1'b0;
    end
    tick();
    check("ack_low", ACK, 1'b0);
    check("busy_low", BUSY, 1'b0);
    check("data_keep", DATA, e.data);
    check("err_keep", ERR, e.err);
  endtask

  initial begin
    logic [2:0]       ra;
    logic [WIDTH-1:0] rv;
    RST  = 1'b1;
    REQ  = 1'b0;
    ADDR = '0;
    for (int i = 0; i < WORDS; i++) begin
      qw[i]  = WIDTH'(8'h10 + i);
      nqw[i] = ~qw[i];
    end
    qw[5]  = 8'hA5;
    nqw[5] = 8'h5A;
    qw[2]  = 8'h3C;
    nqw[2] = 8'hC3 | 8'h08;   // bit 3: Q = NQ = 1
    repeat (3) tick();
    check("rst_ack", ACK, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_data", DATA, 8'h00);
    check("rst_err", ERR, 1'b0);
`ifdef SR_READER_STATS_EN
    check("rst_rdcnt", RD_COUNT, 16'd0);
    check("rst_errcnt", ERR_COUNT, 16'd0);
`endif
    // Request presented together with reset release.
    RST = 1'b0;
    do_read(3'd5, 8'hA5, 1'b0, SETTLE + 3, 0, 8'h00, 1'b0);
    do_read(3'd2, 8'h3C, 1'b1, SETTLE + 3, 0, 8'h00, 1'b0);
`ifdef SR_READER_STATS_EN
    check("rdcnt", RD_COUNT, 16'd1);
    check("errcnt", ERR_COUNT, 16'd1);
`endif
    // Word 0 flips every cycle: all retries used, final B sampled with tog=1.
    toggle_en = 1'b1;
    do_read(3'd0, 8'hFF, 1'b1, (RETRY + 1) * (SETTLE + 2) + 1, 0, 8'h00, 1'b0);
    toggle_en = 1'b0;
    // Word 1 changes during the first CHECK cycle (edge SETTLE+2): one retry.
    do_read(3'd1, 8'h66, 1'b0, 2 * (SETTLE + 2) + 1, SETTLE + 2, 8'h66, 1'b0);
    // REQ dropped right after acceptance: read still completes, ACK pulses.
    do_read(3'd7, 8'h17, 1'b0, SETTLE + 3, 0, 8'h00, 1'b1);

    // Reset in the middle of SETTLE.
    ADDR = 3'd3;
    REQ  = 1'b1;
    tick();
    check("settle_busy", BUSY, 1'b1);
    RST = 1'b1;
    REQ = 1'b0;
    tick();
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_ack", ACK, 1'b0);
    check("midrst_data", DATA, 8'h00);
    check("midrst_err", ERR, 1'b0);
    RST = 1'b0;
    do_read(3'd3, 8'h13, 1'b0, SETTLE + 3, 0, 8'h00, 1'b0);

    for (int n = 0; n < 4; n++) begin
      ra = 3'($urandom_range(1, WORDS - 1));
      rv = WIDTH'($urandom);
      qw[ra]  = rv;
      nqw[ra] = ~rv;
      do_read(ra, rv, 1'b0, SETTLE + 3, 0, 8'h00, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
